hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: MEM_WAIT cycles tolerated before the timeout error is raised.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 Rs1D, Rs2D  input  5 each  source register indices of the instruction in Decode.
REQ-005 Rs1E, Rs2E, RdE  input  5 each  source and destination indices in Execute.
REQ-006 RdM, RdW  input  5 each  destination indices in Memory and Writeback; only bits [4:0] used.
REQ-007 RegWriteM, RegWriteW  input  1 each  register write enables in Memory and Writeback.
REQ-008 ResultSrcE  input  2  Execute result select; 2'b01 marks a load.
REQ-009 PCSrcE  input  1  branch taken or jump resolved in Execute.
REQ-010 mem_req  input  1  Memory stage is performing a data access.
REQ-011 mem_ready  input  1  data memory completes the access this cycle.
REQ-012 ForwardAE, ForwardBE  output  2 each  operand select: 00 regfile, 01 ResultW, 10 ALUResultM.
REQ-013 StallF, StallD, StallE, StallM  output  1 each  hold the PC and the F/D, D/E and E/M registers.
REQ-014 FlushD, FlushE, FlushW  output  1 each  bubble insert into the F/D, D/E and M/W registers.
REQ-015 timeout_err  output  1  sticky; memory wait exceeded TIMEOUT_CYCLES.
REQ-016 stall_cycles  output  32  count of cycles with StallF high.

Function
REQ-017 ForwardAE SHALL be 10 when RegWriteM, RdM!=0 and RdM==Rs1E; otherwise 01 when RegWriteW, RdW!=0 and RdW==Rs1E; otherwise 00. ForwardBE follows the same rule on Rs2E.
REQ-018 Memory has priority over Writeback when both match; register x0 never forwards.
REQ-019 lw_stall SHALL equal (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-020 mem_stall SHALL equal mem_req & ~mem_ready, combinational, effective from the first cycle of the access.
REQ-021 FSM states: RUN, MEM_WAIT, ERR.
REQ-022 RUN goes to MEM_WAIT on mem_stall.
REQ-023 MEM_WAIT goes to RUN on mem_ready, and to ERR when wait_cnt reaches TIMEOUT_CYCLES.
REQ-024 ERR is exited only by rst.
REQ-025 wait_cnt SHALL clear on entry to MEM_WAIT and increment each cycle spent in MEM_WAIT; it saturates and is sized $clog2(TIMEOUT_CYCLES+1).
REQ-026 While mem_stall or in ERR, the block SHALL assert StallF, StallD, StallE, StallM and FlushW, and hold FlushD=FlushE=0.
REQ-027 Otherwise, on lw_stall, the block SHALL assert StallF, StallD and FlushE for exactly one cycle.
REQ-028 Otherwise, on PCSrcE, the block SHALL assert FlushD and FlushE.
REQ-029 If PCSrcE and lw_stall occur together, the branch wins: FlushD and FlushE are asserted and StallF/StallD stay low.
REQ-030 If PCSrcE occurs during mem_stall, the flush SHALL be deferred; the stalled Execute register keeps PCSrcE valid until release.
REQ-031 Release latency: outputs deassert in the same cycle mem_ready rises, and the state returns to RUN at the next edge.
REQ-032 timeout_err SHALL set on entry to ERR and remain high until rst.
REQ-033 stall_cycles SHALL increment when StallF is high and wrap from 2^32-1 to 0.

Reset
REQ-034 When rst is high at a clock edge: state=RUN, wait_cnt=0, timeout_err=0, stall_cycles=0.
REQ-035 While rst is high, all stall and flush outputs SHALL be 0 and ForwardAE/ForwardBE SHALL be 00.
REQ-036 Reset asserted mid-MEM_WAIT or in ERR SHALL return the block to RUN at the next edge.

Structure
REQ-037 hazard_pkg SHALL hold the state enum (RUN, MEM_WAIT, ERR), the forward-select enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the load code RESULT_LOAD=2'b01.
REQ-038 The forwarding logic SHALL be the purely combinational sub-module forward_unit, instantiated once per operand.
REQ-039 The FSM, counters and stall/flush priority logic SHALL reside in hazard_ctrl.

Verification
REQ-040 Forwarding: RegWriteM=1, RdM=5, Rs1E=5, RegWriteW=1, RdW=5 -> ForwardAE=10; then RdM=0 -> ForwardAE=01.
REQ-041 Load-use: ResultSrcE=01, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle; stall_cycles increments by 1.
REQ-042 Branch: PCSrcE=1 with no hazard -> FlushD=FlushE=1, no stalls; PCSrcE=1 with lw_stall -> flushes only.
REQ-043 Miss: mem_req=1, mem_ready=0 for 4 cycles then 1 -> all stalls and FlushW high for 4 cycles, state returns to RUN, stall_cycles=4.
REQ-044 Timeout: TIMEOUT_CYCLES=8, mem_ready held 0 -> timeout_err=1 after 8 MEM_WAIT cycles, stalls persist, rst clears everything.
REQ-045 Reset mid-wait: rst pulsed in cycle 2 of MEM_WAIT -> state=RUN, wait_cnt=0, outputs low while rst is high.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM states, forward selects and the load result code.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // x0 is hardwired to zero, so it never counts as a producer
  function automatic logic rd_hit(
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = datapath side, slave = hazard controller side.
interface hazard_ctrl_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [4:0]  RdM;
  logic [4:0]  RdW;
  logic        RegWriteM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic        mem_req;
  logic        mem_ready;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic        timeout_err;
  logic [31:0] stall_cycles;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
    output mem_req, mem_ready,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  timeout_err, stall_cycles
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
    input  mem_req, mem_ready,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output timeout_err, stall_cycles
  );
endinterface

// File: rtl/forward_unit.sv
// Operand bypass select for one Execute source register.
// Memory-stage result is younger, so it wins over Writeback.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_we_m,
  input  logic       i_we_w,
  output fwd_e       o_fwd
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = rd_hit(i_we_m, i_rd_m, i_rs);
  assign w_hit_w = rd_hit(i_we_w, i_rd_w, i_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_hit_m)      o_fwd = FWD_MEM;
    else if (w_hit_w) o_fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use and branch
// handling, data-memory wait FSM with timeout and stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] W_TO = CW'(TIMEOUT_CYCLES);

  state_e          r_state;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_timeout;
  logic [31:0]     r_stall_cnt;

  fwd_e            w_fwd_a;
  fwd_e            w_fwd_b;
  logic            w_lw_stall;
  logic            w_mem_stall;
  logic            w_hold;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_stall_f;
  logic            w_stall_d;
  logic            w_stall_e;
  logic            w_stall_m;
  logic            w_flush_d;
  logic            w_flush_e;
  logic            w_flush_w;

  forward_unit u_fwd_a (
    .i_rs   (bus.Rs1E),
    .i_rd_m (bus.RdM),
    .i_rd_w (bus.RdW),
    .i_we_m (bus.RegWriteM),
    .i_we_w (bus.RegWriteW),
    .o_fwd  (w_fwd_a)
  );

  forward_unit u_fwd_b (
    .i_rs   (bus.Rs2E),
    .i_rd_m (bus.RdM),
    .i_rd_w (bus.RdW),
    .i_we_m (bus.RegWriteM),
    .i_we_w (bus.RegWriteW),
    .o_fwd  (w_fwd_b)
  );

  assign w_lw_stall = (bus.ResultSrcE == RESULT_LOAD)
                    && (bus.RdE != 5'd0)
                    && ((bus.RdE == bus.Rs1D)
                     || (bus.RdE == bus.Rs2D));

  assign w_mem_stall = bus.mem_req & ~bus.mem_ready;
  assign w_hold      = w_mem_stall || (r_state == ERR);
  assign w_cnt_nxt   = (r_wait_cnt == W_TO) ? r_wait_cnt
                     : r_wait_cnt + CW'(1);

  // Memory hold freezes the whole pipe, so a resolved branch
  // stays in Execute and is flushed once the hold drops.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (rst) begin
      w_stall_f = 1'b0;
    end else if (w_hold) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (bus.PCSrcE) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lw_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall_f) r_stall_cnt <= r_stall_cnt + 32'd1;
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          r_wait_cnt <= w_cnt_nxt;
          if (!w_mem_stall) begin
            r_state <= RUN;
          end else if (w_cnt_nxt == W_TO) begin
            r_state   <= ERR;
            r_timeout <= 1'b1;
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.ForwardAE    = rst ? FWD_RF : w_fwd_a;
  assign bus.ForwardBE    = rst ? FWD_RF : w_fwd_b;
  assign bus.StallF       = w_stall_f;
  assign bus.StallD       = w_stall_d;
  assign bus.StallE       = w_stall_e;
  assign bus.StallM       = w_stall_m;
  assign bus.FlushD       = w_flush_d;
  assign bus.FlushE       = w_flush_e;
  assign bus.FlushW       = w_flush_w;
  assign bus.timeout_err  = r_timeout;
  assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT_CYCLES=8.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk;
  logic rst;
  int   n_tot;
  int   n_bad;
  int   exp_sc;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // {StallF,StallD,StallE,StallM,FlushW,FlushD,FlushE}
  function automatic logic [6:0] ctl();
    return {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
            bus.FlushW, bus.FlushD, bus.FlushE};
  endfunction

  task automatic clr();
    bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
    bus.RdE = 0; bus.RdM = 0; bus.RdW = 0;
    bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.ResultSrcE = 2'b00; bus.PCSrcE = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    exp_sc = 0;
    clr();
    // reset with every hazard source active
    rst = 1'b1;
    bus.mem_req = 1; bus.PCSrcE = 1;
    bus.RegWriteM = 1; bus.RdM = 5; bus.Rs1E = 5;
    step();
    step();
    sample();
    chk("rst_ctl", 32'(ctl()), 32'h0);
    chk("rst_fwdA", 32'(bus.ForwardAE), 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(RUN));
    chk("rst_sc", bus.stall_cycles, 32'd0);
    chk("rst_to", 32'(bus.timeout_err), 32'd0);
    step();
    rst = 1'b0;
    clr();

    // forwarding
    bus.RegWriteM = 1; bus.RdM = 5; bus.Rs1E = 5;
    bus.RegWriteW = 1; bus.RdW = 5;
    sample();
    chk("fwdA_mem", 32'(bus.ForwardAE), 32'h2);
    chk("fwdB_none", 32'(bus.ForwardBE), 32'h0);
    bus.RdM = 0;
    sample();
    chk("fwdA_wb", 32'(bus.ForwardAE), 32'h1);
    bus.RdM = 7; bus.Rs2E = 7;
    sample();
    chk("fwdB_mem", 32'(bus.ForwardBE), 32'h2);
    bus.RegWriteM = 0;
    sample();
    chk("fwdB_nowe", 32'(bus.ForwardBE), 32'h0);
    bus.RdW = 0; bus.Rs1E = 0;
    sample();
    chk("fwdA_x0", 32'(bus.ForwardAE), 32'h0);
    step();
    clr();

    // load-use
    bus.ResultSrcE = 2'b01; bus.RdE = 3; bus.Rs2D = 3;
    sample();
    chk("lw_ctl", 32'(ctl()), 32'b1100001);
    step();
    exp_sc++;
    clr();
    sample();
    chk("lw_gone", 32'(ctl()), 32'h0);
    chk("lw_sc", bus.stall_cycles, 32'(exp_sc));
    bus.ResultSrcE = 2'b01; bus.RdE = 0; bus.Rs1D = 0;
    sample();
    chk("lw_x0", 32'(ctl()), 32'h0);
    step();
    clr();

    // branch, then branch racing a load-use
    bus.PCSrcE = 1;
    sample();
    chk("br_ctl", 32'(ctl()), 32'b0000011);
    bus.ResultSrcE = 2'b01; bus.RdE = 4; bus.Rs1D = 4;
    sample();
    chk("br_lw_ctl", 32'(ctl()), 32'b0000011);
    step();
    clr();

    // 4-cycle miss with a deferred branch
    bus.mem_req = 1; bus.PCSrcE = 1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("miss_ctl%0d", i), 32'(ctl()), 32'b1111100);
      step();
      exp_sc++;
    end
    bus.mem_ready = 1;
    sample();
    chk("miss_rel", 32'(ctl()), 32'b0000011);
    chk("miss_st", 32'(dut.r_state), 32'(MEM_WAIT));
    step();
    clr();
    sample();
    chk("miss_run", 32'(dut.r_state), 32'(RUN));
    chk("miss_sc", bus.stall_cycles, 32'(exp_sc));

    // timeout after 8 MEM_WAIT cycles
    step();
    bus.mem_req = 1;
    for (int i = 0; i < 9; i++) begin
      sample();
      chk($sformatf("to_pre%0d", i), 32'(bus.timeout_err), 32'd0);
      step();
      exp_sc++;
    end
    sample();
    chk("to_set", 32'(bus.timeout_err), 32'd1);
    chk("to_st", 32'(dut.r_state), 32'(ERR));
    chk("to_sc", bus.stall_cycles, 32'(exp_sc));
    bus.mem_req = 0;
    sample();
    chk("err_ctl", 32'(ctl()), 32'b1111100);
    step();
    sample();
    chk("err_sticky", 32'(bus.timeout_err), 32'd1);
    rst = 1;
    sample();
    chk("err_rst_ctl", 32'(ctl()), 32'h0);
    step();
    rst = 0;
    sample();
    chk("err_rst_to", 32'(bus.timeout_err), 32'd0);
    chk("err_rst_st", 32'(dut.r_state), 32'(RUN));
    chk("err_rst_sc", bus.stall_cycles, 32'd0);

    // reset pulsed in cycle 2 of MEM_WAIT
    bus.mem_req = 1;
    step();
    step();
    sample();
    chk("mw_st", 32'(dut.r_state), 32'(MEM_WAIT));
    chk("mw_cnt", 32'(dut.r_wait_cnt), 32'd1);
    rst = 1;
    bus.RegWriteW = 1; bus.RdW = 9; bus.Rs2E = 9;
    sample();
    chk("mw_rst_ctl", 32'(ctl()), 32'h0);
    chk("mw_rst_fwdB", 32'(bus.ForwardBE), 32'h0);
    step();
    rst = 0;
    clr();
    sample();
    chk("mw_rst_st", 32'(dut.r_state), 32'(RUN));
    chk("mw_rst_cnt", 32'(dut.r_wait_cnt), 32'd0);
    chk("mw_rst_sc", bus.stall_cycles, 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
